// File: rtl/stage_eval_pkg.sv
// -----------------------------------------------------------------------------
// stage_eval_pkg
// Shared definitions for the stage result evaluator:
//   - eval_state_t      : evaluator FSM states (IDLE, REQ, ACCUM, CMP, DONE)
//   - ACC_WIDTH_DEFAULT : default stage accumulator width
//   - ACC_SAT_MAX       : saturation ceiling for the default accumulator width
//   - sat_max()         : saturation ceiling for an arbitrary accumulator width
// -----------------------------------------------------------------------------
package stage_eval_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACCUM = 3'd2,
        CMP   = 3'd3,
        DONE  = 3'd4
    } eval_state_t;

    localparam int ACC_WIDTH_DEFAULT = 20;

    localparam logic [ACC_WIDTH_DEFAULT-1:0] ACC_SAT_MAX = {ACC_WIDTH_DEFAULT{1'b1}};

    // All-ones value of a w-bit accumulator, returned in a 32-bit container.
    function automatic logic [31:0] sat_max(input int w);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/stage_result_evaluator_if.sv
// -----------------------------------------------------------------------------
// stage_result_evaluator_if
// Bundles the two handshakes the evaluator takes part in:
//   stage parameter channel : stage_req / stage_index  ->  stage_ack /
//                             stage_size / stage_threshold
//   haar value stream       : haar_valid / haar_value  ->  haar_ready
// Modports:
//   slave  : the evaluator's view (issues stage_req, consumes haar values)
//   master : the environment's view (parameter ROM reader + haar producer)
// -----------------------------------------------------------------------------
interface stage_result_evaluator_if #(
    parameter int DATA_WIDTH_8  = 8,
    parameter int DATA_WIDTH_12 = 12,
    parameter int DATA_WIDTH_16 = 16
);
    logic                     stage_req;
    logic [DATA_WIDTH_8-1:0]  stage_index;
    logic                     stage_ack;
    logic [DATA_WIDTH_8-1:0]  stage_size;
    logic [DATA_WIDTH_16-1:0] stage_threshold;
    logic                     haar_valid;
    logic [DATA_WIDTH_12-1:0] haar_value;
    logic                     haar_ready;

    modport slave (
        output stage_req,
        output stage_index,
        input  stage_ack,
        input  stage_size,
        input  stage_threshold,
        input  haar_valid,
        input  haar_value,
        output haar_ready
    );

    modport master (
        input  stage_req,
        input  stage_index,
        output stage_ack,
        output stage_size,
        output stage_threshold,
        output haar_valid,
        output haar_value,
        input  haar_ready
    );
endinterface

// File: rtl/stage_result_evaluator_sat_accumulator.sv
// -----------------------------------------------------------------------------
// sat_accumulator
// Registered unsigned accumulator that clamps at all-ones instead of wrapping.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : force accumulator to zero (has priority over add_en)
//   add_en     : add add_value this cycle
//   add_value  : IN_WIDTH-bit unsigned addend (zero-extended)
//   acc        : current accumulator value
// Requires ACC_WIDTH >= IN_WIDTH.
// -----------------------------------------------------------------------------
module sat_accumulator
    import stage_eval_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
    parameter int IN_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 add_en,
    input  logic [IN_WIDTH-1:0]  add_value,
    output logic [ACC_WIDTH-1:0] acc
);

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {ACC_WIDTH{1'b1}};

    // One extra bit catches the carry out; a set carry means the sum overflowed.
    logic [ACC_WIDTH:0] sum_s;

    // Widened sum of the current value and the zero-extended addend
    always_comb begin
        sum_s = {1'b0, acc} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, add_value};
    end

    // Accumulator register with clear priority and clamp on overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= {ACC_WIDTH{1'b0}};
        end else if (clear) begin
            acc <= {ACC_WIDTH{1'b0}};
        end else if (add_en) begin
            acc <= sum_s[ACC_WIDTH] ? SAT_MAX : sum_s[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/stage_result_evaluator.sv
// -----------------------------------------------------------------------------
// stage_result_evaluator
// Consumer end of the cascade classifier pipeline. For each detection window
// it fetches every stage's (size, threshold), sums that many haar values in a
// saturating accumulator and compares against the threshold. A failing stage
// rejects the window at once; passing all NUM_STAGE stages reports a face.
//
// Ports:
//   clk_fpga, reset_fpga : clock, asynchronous active-high reset
//   start                : pulse, begin a new window (honoured only when idle)
//   busy                 : high from accepted start until the verdict cycle
//   bus (slave modport)  : stage parameter req/ack and haar valid/ready stream
//   result_valid         : one-cycle verdict strobe
//   result_face          : 1 = every stage passed
//   result_stage         : rejecting stage, or NUM_STAGE for a face
//
// Optional feature, macro STAGE_TRACE_EN:
//   trace_valid          : high in every compare cycle
//   trace_sum            : the compared stage sum, held until the next compare
// -----------------------------------------------------------------------------
module stage_result_evaluator
    import stage_eval_pkg::*;
#(
    parameter int DATA_WIDTH_8  = 8,
    parameter int DATA_WIDTH_12 = 12,
    parameter int DATA_WIDTH_16 = 16,
    parameter int ACC_WIDTH     = ACC_WIDTH_DEFAULT,
    parameter int NUM_STAGE     = 25
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     start,
    output logic                     busy,
    stage_result_evaluator_if.slave  bus,
    output logic                     result_valid,
    output logic                     result_face,
    output logic [DATA_WIDTH_8-1:0]  result_stage
`ifdef STAGE_TRACE_EN
    ,
    output logic                     trace_valid,
    output logic [ACC_WIDTH-1:0]     trace_sum
`endif
);

    localparam logic [DATA_WIDTH_8-1:0] ZERO8      = {DATA_WIDTH_8{1'b0}};
    localparam logic [DATA_WIDTH_8-1:0] ONE8       = {{(DATA_WIDTH_8-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH_8-1:0] LAST_STAGE = DATA_WIDTH_8'(NUM_STAGE - 1);
    localparam logic [DATA_WIDTH_8-1:0] FACE_STAGE = DATA_WIDTH_8'(NUM_STAGE);
    // Common width so the sum and the threshold are both compared zero-extended.
    localparam int CMP_W = (ACC_WIDTH > DATA_WIDTH_16) ? ACC_WIDTH : DATA_WIDTH_16;

    eval_state_t              state;
    logic                     stage_req_r;
    logic [DATA_WIDTH_8-1:0]  stage_index_r;
    logic                     haar_ready_r;
    logic [DATA_WIDTH_8-1:0]  size_r;
    logic [DATA_WIDTH_16-1:0] thr_r;
    logic [DATA_WIDTH_8-1:0]  count_r;

    logic [ACC_WIDTH-1:0]     acc_s;
    logic                     xfer_s;
    logic                     pass_s;
    logic                     acc_clear_s;

    assign bus.stage_req   = stage_req_r;
    assign bus.stage_index = stage_index_r;
    assign bus.haar_ready  = haar_ready_r;

    // Transfer qualification, stage pass test and accumulator clear control
    always_comb begin
        xfer_s      = 1'b0;
        pass_s      = 1'b0;
        acc_clear_s = 1'b0;
        if ((state == ACCUM) && haar_ready_r && bus.haar_valid) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
        if (CMP_W'(acc_s) >= CMP_W'(thr_r)) begin
            pass_s = 1'b1;
        end else begin
            pass_s = 1'b0;
        end
        // Fresh sum for a new window and for every following stage.
        if ((state == IDLE) && start) begin
            acc_clear_s = 1'b1;
        end else if ((state == CMP) && pass_s) begin
            acc_clear_s = 1'b1;
        end else begin
            acc_clear_s = 1'b0;
        end
    end

    sat_accumulator #(
        .ACC_WIDTH (ACC_WIDTH),
        .IN_WIDTH  (DATA_WIDTH_12)
    ) u_acc (
        .clk       (clk_fpga),
        .rst       (reset_fpga),
        .clear     (acc_clear_s),
        .add_en    (xfer_s),
        .add_value (bus.haar_value),
        .acc       (acc_s)
    );

    // Window sequencing FSM with all handshake and verdict outputs registered
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state         <= IDLE;
            busy          <= 1'b0;
            stage_req_r   <= 1'b0;
            stage_index_r <= ZERO8;
            haar_ready_r  <= 1'b0;
            size_r        <= ZERO8;
            thr_r         <= {DATA_WIDTH_16{1'b0}};
            count_r       <= ZERO8;
            result_valid  <= 1'b0;
            result_face   <= 1'b0;
            result_stage  <= ZERO8;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy          <= 1'b1;
                        stage_index_r <= ZERO8;
                        stage_req_r   <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    // stage_req stays up through the ack cycle and drops after it.
                    if (bus.stage_ack) begin
                        stage_req_r <= 1'b0;
                        size_r      <= bus.stage_size;
                        thr_r       <= bus.stage_threshold;
                        count_r     <= ZERO8;
                        if (bus.stage_size == ZERO8) begin
                            state <= CMP;
                        end else begin
                            haar_ready_r <= 1'b1;
                            state        <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer_s) begin
                        count_r <= count_r + ONE8;
                        // size_r is nonzero here, so size_r - 1 cannot underflow.
                        if (count_r == (size_r - ONE8)) begin
                            haar_ready_r <= 1'b0;
                            state        <= CMP;
                        end
                    end
                end
                CMP: begin
                    if (pass_s) begin
                        if (stage_index_r == LAST_STAGE) begin
                            result_valid <= 1'b1;
                            result_face  <= 1'b1;
                            result_stage <= FACE_STAGE;
                            busy         <= 1'b0;
                            state        <= DONE;
                        end else begin
                            stage_index_r <= stage_index_r + ONE8;
                            stage_req_r   <= 1'b1;
                            state         <= REQ;
                        end
                    end else begin
                        result_valid <= 1'b1;
                        result_face  <= 1'b0;
                        result_stage <= stage_index_r;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy         <= 1'b0;
                    stage_req_r  <= 1'b0;
                    haar_ready_r <= 1'b0;
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

`ifdef STAGE_TRACE_EN
    logic [ACC_WIDTH-1:0] trace_hold_r;

    // Keep the last compared sum, since the accumulator clears on a pass
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            trace_hold_r <= {ACC_WIDTH{1'b0}};
        end else if (state == CMP) begin
            trace_hold_r <= acc_s;
        end
    end

    // Present the live sum during the compare cycle, the held copy afterwards
    always_comb begin
        trace_valid = 1'b0;
        trace_sum   = trace_hold_r;
        if (state == CMP) begin
            trace_valid = 1'b1;
            trace_sum   = acc_s;
        end else begin
            trace_valid = 1'b0;
            trace_sum   = trace_hold_r;
        end
    end
`endif

endmodule

// File: tb/tb_stage_result_evaluator.sv
module tb_stage_result_evaluator;

    localparam int NS   = 2;
    localparam int AW   = 12;
    localparam int MAXH = 8;
    localparam int SAT  = 4095;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       result_valid;
    logic       result_face;
    logic [7:0] result_stage;
`ifdef STAGE_TRACE_EN
    logic          trace_valid;
    logic [AW-1:0] trace_sum;
`endif

    stage_result_evaluator_if #(.DATA_WIDTH_8(8), .DATA_WIDTH_12(12), .DATA_WIDTH_16(16)) bus ();

    stage_result_evaluator #(
        .DATA_WIDTH_8(8), .DATA_WIDTH_12(12), .DATA_WIDTH_16(16),
        .ACC_WIDTH(AW), .NUM_STAGE(NS)
    ) dut (
        .clk_fpga     (clk),
        .reset_fpga   (rst),
        .start        (start),
        .busy         (busy),
        .bus          (bus),
        .result_valid (result_valid),
        .result_face  (result_face),
        .result_stage (result_stage)
`ifdef STAGE_TRACE_EN
        ,
        .trace_valid  (trace_valid),
        .trace_sum    (trace_sum)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Window configuration and behavioural expectations.
    int cfg_size [NS];
    int cfg_thr  [NS];
    int hv       [NS][MAXH];
    int ack_delay = 0;
    int valid_pct = 0;
    int xcnt [NS];
    int req_log [$];
    int ready_cycles = 0;
    bit win_active = 1'b0;
    int exp_face = 0, exp_stage = 0, exp_last = 0;
    int last_face = 0, last_stage = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Verdict from the rules: each stage sum is min(total, 2^AW-1); first stage
    // whose sum is below its threshold rejects, otherwise a face.
    function automatic void model();
        int total;
        exp_face  = 1;
        exp_stage = NS;
        exp_last  = NS - 1;
        for (int s = 0; s < NS; s++) begin
            total = 0;
            for (int i = 0; i < cfg_size[s]; i++) total += hv[s][i];
            if (total > SAT) total = SAT;
            if (total < cfg_thr[s]) begin
                exp_face  = 0;
                exp_stage = s;
                exp_last  = s;
                break;
            end
        end
    endfunction

    task automatic set_stage(input int s, input int size, input int thr, input int v0, input int v1, input int v2);
        cfg_size[s] = size;
        cfg_thr[s]  = thr;
        for (int i = 0; i < MAXH; i++) hv[s][i] = 0;
        hv[s][0] = v0; hv[s][1] = v1; hv[s][2] = v2;
    endtask

    // Stage parameter ROM reader with a programmable ack delay.
    initial begin
        int wait_cnt;
        int k;
        wait_cnt = 0;
        bus.stage_ack = 1'b0;
        bus.stage_size = 8'd0;
        bus.stage_threshold = 16'd0;
        forever begin
            @(negedge clk);
            if (bus.stage_req && !bus.stage_ack && !rst) begin
                if (wait_cnt >= ack_delay) begin
                    k = int'(bus.stage_index);
                    if (k >= NS) k = 0;
                    bus.stage_ack = 1'b1;
                    bus.stage_size = 8'(cfg_size[k]);
                    bus.stage_threshold = 16'(cfg_thr[k]);
                    req_log.push_back(int'(bus.stage_index));
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                bus.stage_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Haar producer: random valid, values taken in order per stage.
    initial begin
        int s;
        bus.haar_valid = 1'b0;
        bus.haar_value = 12'd0;
        forever begin
            @(negedge clk);
            s = int'(bus.stage_index);
            if (s >= NS) s = 0;
            bus.haar_valid = ($urandom_range(99, 0) < valid_pct);
            bus.haar_value = (xcnt[s] < MAXH) ? 12'(hv[s][xcnt[s]]) : 12'($urandom);
            if (bus.haar_ready) ready_cycles++;
            if (bus.haar_valid && bus.haar_ready && !rst) xcnt[s]++;
        end
    end

    // Compare process: verdict against the model, held outputs between verdicts.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (result_valid) begin
                    check("verdict_expected", int'(win_active), 1);
                    check("result_face", int'(result_face), exp_face);
                    check("result_stage", int'(result_stage), exp_stage);
                    check("busy_at_verdict", int'(busy), 0);
                    last_face  = exp_face;
                    last_stage = exp_stage;
                end else begin
                    check("hold_face", int'(result_face), last_face);
                    check("hold_stage", int'(result_stage), last_stage);
                end
            end
        end
    end

    task automatic pulse_reset();
        rst = 1'b1;
        last_face = 0;
        last_stage = 0;
        win_active = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        for (int s = 0; s < NS; s++) xcnt[s] = 0;
        req_log.delete();
        ready_cycles = 0;
    endtask

    // Runs one window from an idle negedge; lit_face < 0 skips literal pins.
    task automatic run_window(input int dly, input int vpct, input bit extra_starts,
                              input bit done_start, input int lit_face, input int lit_stage);
        bit got;
        ack_delay = dly;
        valid_pct = vpct;
        clear_obs();
        model();
        if (lit_face >= 0) begin
            check("model_face", exp_face, lit_face);
            check("model_stage", exp_stage, lit_stage);
        end
        win_active = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (result_valid) begin
                got = 1'b1;
                break;
            end
            start = extra_starts && busy && ($urandom_range(3, 0) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        check("verdict_seen", int'(got), 1);
        if (got) begin
            if (done_start) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            win_active = 1'b0;
            check("busy_after_done", int'(busy), 0);
            @(negedge clk);
            check("busy_stays_idle", int'(busy), 0);
            check("stages_requested", req_log.size(), exp_last + 1);
            for (int i = 0; i < req_log.size() && i <= exp_last; i++)
                check("req_order", req_log[i], i);
            for (int s = 0; s < NS; s++)
                check("transfers", xcnt[s], (s <= exp_last) ? cfg_size[s] : 0);
        end else begin
            pulse_reset();
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int s = 0; s < NS; s++) begin
            set_stage(s, 0, 0, 0, 0, 0);
            xcnt[s] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_stage_req", int'(bus.stage_req), 0);
        check("rst_stage_index", int'(bus.stage_index), 0);
        check("rst_haar_ready", int'(bus.haar_ready), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_result_face", int'(result_face), 0);
        check("rst_result_stage", int'(result_stage), 0);
        rst = 1'b0;
        @(negedge clk);

        // Two passing stages -> face.
        set_stage(0, 3, 100, 40, 40, 40);
        set_stage(1, 2, 50, 30, 30, 0);
        run_window(0, 100, 1'b0, 1'b0, 1, 2);

        // Early reject at stage 0; stage 1 never requested; start in DONE ignored.
        set_stage(0, 2, 100, 10, 20, 0);
        set_stage(1, 1, 0, 5, 0, 0);
        run_window(0, 100, 1'b0, 1'b1, 0, 0);

        // Empty stages: thr 0 passes, thr 1 fails; never ready.
        set_stage(0, 0, 0, 9, 9, 9);
        set_stage(1, 0, 1, 9, 9, 9);
        run_window(2, 100, 1'b0, 1'b0, 0, 1);
        check("no_ready_size0_fail", ready_cycles, 0);
        set_stage(1, 0, 0, 9, 9, 9);
        run_window(1, 100, 1'b0, 1'b0, 1, 2);
        check("no_ready_size0_pass", ready_cycles, 0);

        // Saturation: 3 x 4095 clamps at 4095, which is below 4096.
        set_stage(0, 3, 4096, 4095, 4095, 4095);
        set_stage(1, 1, 7, 7, 0, 0);
        run_window(0, 100, 1'b0, 1'b0, 0, 0);
        set_stage(0, 3, 4095, 4095, 4095, 4095);
        run_window(0, 100, 1'b0, 1'b0, 1, 2);

        // Slow ack, sparse valid, spurious starts while busy.
        set_stage(0, 4, 200, 60, 70, 80);
        hv[0][3] = 5;
        set_stage(1, 3, 300, 100, 100, 100);
        run_window(5, 40, 1'b1, 1'b1, 1, 2);

        // Reset in the middle of ACCUM aborts the window.
        set_stage(0, 5, 10, 1, 2, 3);
        set_stage(1, 1, 0, 0, 0, 0);
        ack_delay = 0;
        valid_pct = 100;
        clear_obs();
        win_active = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.haar_ready && xcnt[0] >= 2) break;
            @(negedge clk);
        end
        check("reached_accum", int'(bus.haar_ready), 1);
        rst = 1'b1;
        last_face = 0;
        last_stage = 0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_haar_ready", int'(bus.haar_ready), 0);
        check("mid_rst_stage_req", int'(bus.stage_req), 0);
        check("mid_rst_result_face", int'(result_face), 0);
        check("mid_rst_result_stage", int'(result_stage), 0);
        @(negedge clk);
        rst = 1'b0;
        // win_active is 0: any verdict here is flagged by the compare process.
        repeat (10) @(negedge clk);
        set_stage(0, 2, 30, 20, 15, 0);
        set_stage(1, 2, 40, 10, 10, 0);
        run_window(0, 100, 1'b0, 1'b0, 0, 1);

        // Randomized windows.
        for (int w = 0; w < 30; w++) begin
            for (int s = 0; s < NS; s++) begin
                cfg_size[s] = $urandom_range(6, 0);
                cfg_thr[s]  = $urandom_range(5000, 0);
                for (int i = 0; i < MAXH; i++) hv[s][i] = $urandom_range(1500, 0);
            end
            run_window($urandom_range(5, 0), $urandom_range(100, 20),
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stage_result_evaluator.md
Name: stage_result_evaluator

Overview:
- Consumer end of the classifier pipeline: accepts the stream of per-classifier haar values produced by the stage classifier fetch/compute block and accumulates them per stage.
- Compares each stage sum against that stage's threshold. Advances to the next stage on pass, or rejects the window early on fail.
- Requests per-stage parameters (classifier count, threshold) over a req/ack handshake from the stage parameter ROM reader.
- Emits one face/no-face verdict per detection window.

Parameters:
- DATA_WIDTH_8, 8, stage index and stage size width
- DATA_WIDTH_12, 12, haar value width (unsigned)
- DATA_WIDTH_16, 16, stage threshold width (unsigned)
- ACC_WIDTH, 20, stage accumulator width (saturating)
- NUM_STAGE, 25, stages a window must pass to be a face (1..255)

Ports:
- clk_fpga  in  1  system clock
- reset_fpga  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin evaluating a new window
- busy  out  1  high from accepted start until result_valid
- stage_req  out  1  request parameters for stage_index
- stage_index  out  DATA_WIDTH_8  stage currently evaluated
- stage_ack  in  1  stage_size/stage_threshold valid this cycle
- stage_size  in  DATA_WIDTH_8  classifiers in the requested stage
- stage_threshold  in  DATA_WIDTH_16  pass threshold for the requested stage
- haar_valid  in  1  haar_value valid
- haar_value  in  DATA_WIDTH_12  one classifier result
- haar_ready  out  1  block accepts a haar value
- result_valid  out  1  one-cycle verdict strobe
- result_face  out  1  1 = all NUM_STAGE stages passed
- result_stage  out  DATA_WIDTH_8  rejecting stage index, or NUM_STAGE on face

Behaviour:
- Reset (asynchronous, any state): all outputs 0; state IDLE; accumulator 0; counters 0.
- FSM states: IDLE, REQ, ACCUM, CMP, DONE.
- IDLE
  - start=1 → clear accumulator, stage_index=0, go to REQ.
  - start in any state other than IDLE is ignored.
- REQ
  - stage_req=1 held until stage_ack.
  - On stage_ack: latch stage_size and stage_threshold, clear classifier count.
  - Latched size 0 → go to CMP with sum 0. Otherwise go to ACCUM.
  - stage_req drops the cycle after stage_ack.
- ACCUM
  - haar_ready=1. A transfer occurs when haar_valid & haar_ready.
  - Per transfer: acc += zero-extended haar_value; count++.
  - The accumulator saturates at 2^ACC_WIDTH-1 and never wraps.
  - The transfer with count == size-1 moves to CMP; haar_ready is 0 the next cycle.
  - haar_valid while not in ACCUM is not consumed.
- CMP (1 cycle)
  - Pass condition: acc >= zero-extended threshold.
  - Pass and stage_index == NUM_STAGE-1 → DONE with face=1, result_stage=NUM_STAGE.
  - Pass otherwise → stage_index++, acc=0, go to REQ.
  - Fail → DONE with face=0, result_stage=stage_index.
- DONE
  - result_valid=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
  - result_face and result_stage hold until the next result_valid.
  - A start in the DONE cycle is ignored.
- Latency
  - Minimum per stage: REQ (≥1 cycle incl. ack) + size transfer cycles + 1 CMP cycle.
  - Verdict: 1 cycle after the final CMP.
- Reset asserted mid-window aborts the window. No result_valid is produced for it.

Optional Feature:
- Macro: STAGE_TRACE_EN.
- When defined, two extra outputs are added:
  - trace_valid (1 bit): pulses in every CMP cycle.
  - trace_sum (ACC_WIDTH bits): the compared accumulator value, held until the next pulse.
- When undefined, these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package stage_eval_pkg holds:
  - FSM state enum (IDLE, REQ, ACCUM, CMP, DONE).
  - ACC_WIDTH default and the saturation max constant.
- One natural sub-module: sat_accumulator (clear, add-enable, saturating add). Instantiate it once.

Test Plan:
- NUM_STAGE=2; stage0 size 3 thr 100, haar 40,40,40 → pass; stage1 size 2 thr 50, haar 30,30 → result_valid with face=1, result_stage=2.
- Stage0 size 2 thr 100, haar 10,20 → face=0, result_stage=0; stage1 never requested.
- Stage size 0 with thr 0 → immediate pass; with thr 1 → fail at that stage. No haar_ready assertion in either case.
- ACC_WIDTH=12, 3 values of 4095, thr 4095 → accumulator holds 4095 (no wrap) → pass.
- haar_valid toggled randomly and stage_ack delayed 5 cycles → exactly size transfers accepted; start pulses while busy ignored.
- reset_fpga pulsed mid-ACCUM → all outputs 0 immediately; next start evaluates correctly from stage 0.
